// File: rtl/circ_queue_pkg.sv
// Shared types and constants for the circular sample queue.
package circ_queue_pkg;

  // Readout sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2
  } seq_state_e;

  // Trigger mode encodings for seq_mode
  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_REQ  = 1'b1;

endpackage

// File: rtl/circ_queue_ram.sv
// Simple dual-port sample RAM: one write port and one registered read port.
// The array itself carries no reset; only the read data register does.
module circ_queue_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data only advances on a read so the output holds between passes
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  // Registered read data (one-cycle read latency)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/circ_seq_queue.sv
// Circular sample queue keeping the latest DEPTH samples, with a
// non-destructive oldest-to-newest readout pass started automatically
// when full (AUTO) or on request (REQ).
module circ_seq_queue
  import circ_queue_pkg::*;
#(
  parameter int   DATA_W = 16,
  parameter int   DEPTH  = 1024,
  localparam int  CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt_smpl,
  input  logic [DATA_W-1:0] new_smpl,
  input  logic              seq_mode,
  input  logic              seq_req,
  output logic              ready,
  output logic              sequencing,
  output logic              smpl_vld,
  output logic [DATA_W-1:0] smpl_out,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  seq_state_e       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_base_q, rd_base_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [AW-1:0]    base_q, base_d;
  logic             vld_q, vld_d;

  logic             wr_acc;
  logic             trig;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;

  // Write side: pointer/occupancy bookkeeping, overwriting the oldest when full
  always_comb begin
    wr_acc    = wrt_smpl && (state_q == IDLE);
    wr_ptr_d  = wr_ptr_q;
    rd_base_d = rd_base_q;
    count_d   = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q == DEPTH_CNT) rd_base_d = rd_base_q + 1'b1;
      else                      count_d   = count_q + 1'b1;
    end
  end

  // Readout sequencer: trigger uses post-write occupancy so a same-cycle write is included
  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    len_d    = len_q;
    base_d   = base_q;
    rd_en    = 1'b0;
    trig     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seq_mode == MODE_AUTO) trig = wr_acc && (count_d == DEPTH_CNT);
        else                       trig = seq_req && (count_d != '0);
        if (trig) begin
          state_d  = READ;
          len_d    = count_d;
          base_d   = rd_base_d;
          rd_idx_d = '0;
        end
      end
      READ: begin
        rd_en    = 1'b1;
        rd_idx_d = rd_idx_q + 1'b1;
        if (rd_idx_q == len_q - CNT_W'(1)) state_d = LAST;
      end
      LAST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    vld_d = (state_q == READ);
  end

  // All queue and sequencer state, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_base_q <= '0;
      count_q   <= '0;
      rd_idx_q  <= '0;
      len_q     <= '0;
      base_q    <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_base_q <= rd_base_d;
      count_q   <= count_d;
      rd_idx_q  <= rd_idx_d;
      len_q     <= len_d;
      base_q    <= base_d;
      vld_q     <= vld_d;
    end
  end

  assign rd_addr = base_q + rd_idx_q[AW-1:0];

  circ_queue_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (new_smpl),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (smpl_out)
  );

  assign sequencing = (state_q != IDLE);
  assign ready      = (state_q == IDLE);
  assign smpl_vld   = vld_q;
  assign full       = (count_q == DEPTH_CNT);
  assign empty      = (count_q == '0);
  assign count      = count_q;

endmodule

// File: tb/tb_circ_seq_queue.sv
// Directed self-checking bench: a DEPTH=8 instance for the functional
// scenarios and a DEPTH=1024 instance for the overwrite/wrap scenario.
module tb_circ_seq_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // DEPTH=8 instance signals
  logic        wrt8 = 1'b0, mode8 = 1'b0, req8 = 1'b0;
  logic [15:0] new8 = '0;
  logic        ready8, seq8, vld8, full8, empty8;
  logic [15:0] out8;
  logic [3:0]  count8;

  // DEPTH=1024 instance signals
  logic        wrtk = 1'b0;
  logic [15:0] newk = '0;
  logic        readyk, seqk, vldk, fullk, emptyk;
  logic [15:0] outk;
  logic [10:0] countk;

  int checks = 0;
  int failures = 0;

  logic [15:0] q8[$];
  logic [15:0] qk[$];
  int seq_cnt8 = 0, vld_cnt8 = 0, viol8 = 0;

  always #5 clk = ~clk;

  circ_seq_queue #(.DATA_W(16), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .wrt_smpl(wrt8), .new_smpl(new8),
    .seq_mode(mode8), .seq_req(req8), .ready(ready8), .sequencing(seq8),
    .smpl_vld(vld8), .smpl_out(out8), .full(full8), .empty(empty8),
    .count(count8)
  );

  circ_seq_queue #(.DATA_W(16), .DEPTH(1024)) dutk (
    .clk(clk), .rst(rst), .wrt_smpl(wrtk), .new_smpl(newk),
    .seq_mode(1'b0), .seq_req(1'b0), .ready(readyk), .sequencing(seqk),
    .smpl_vld(vldk), .smpl_out(outk), .full(fullk), .empty(emptyk),
    .count(countk)
  );

  // Capture pass samples and pass lengths away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (seq8) seq_cnt8++;
      if (vld8) begin
        vld_cnt8++;
        q8.push_back(out8);
      end
      if (vld8 && !seq8) viol8++;
      if (vldk) qk.push_back(outk);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the DEPTH=8 instance, then release strobes
  task automatic applyStimulus(input logic wr, input logic [15:0] data,
                               input logic req);
    wrt8 = wr;
    new8 = data;
    req8 = req;
    @(negedge clk);
    wrt8 = 1'b0;
    req8 = 1'b0;
  endtask

  task automatic clearMon8();
    q8.delete();
    seq_cnt8 = 0;
    vld_cnt8 = 0;
  endtask

  task automatic waitIdle8(input string tag);
    for (int i = 0; i < 40 && seq8; i++) @(negedge clk);
    checkOutput(tag, {31'd0, seq8}, 32'd0);
  endtask

  // Expect a pass of n consecutive values starting at first
  task automatic checkPass8(input string tag, input int first, input int n);
    checkOutput({tag, "_seq_len"}, seq_cnt8, n + 1);
    checkOutput({tag, "_vld_len"}, vld_cnt8, n);
    checkOutput({tag, "_size"}, q8.size(), n);
    for (int i = 0; i < n && i < q8.size(); i++)
      checkOutput($sformatf("%s_smp%0d", tag, i), {16'd0, q8[i]}, first + i);
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    checkOutput("rst_seq",   {31'd0, seq8},   0);
    checkOutput("rst_vld",   {31'd0, vld8},   0);
    checkOutput("rst_out",   {16'd0, out8},   0);
    checkOutput("rst_full",  {31'd0, full8},  0);
    checkOutput("rst_empty", {31'd0, empty8}, 1);
    checkOutput("rst_ready", {31'd0, ready8}, 1);
    checkOutput("rst_count", {28'd0, count8}, 0);

    // AUTO fill: pass starts on the 8th write
    mode8 = 1'b0;
    clearMon8();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'(i), 1'b0);
    checkOutput("fill_no_early", {31'd0, seq8}, 0);
    applyStimulus(1'b1, 16'h0007, 1'b0);
    checkOutput("fill_trig", {31'd0, seq8}, 1);
    waitIdle8("fill_done");
    checkPass8("fill", 0, 8);
    checkOutput("fill_full",  {31'd0, full8},  1);
    checkOutput("fill_count", {28'd0, count8}, 8);

    // Overwrite plus back-pressure during the pass
    clearMon8();
    applyStimulus(1'b1, 16'h0008, 1'b0);
    @(negedge clk);
    checkOutput("bp_ready", {31'd0, ready8}, 0);
    applyStimulus(1'b1, 16'h0099, 1'b0);
    checkOutput("bp_count", {28'd0, count8}, 8);
    waitIdle8("ovw_done");
    checkPass8("ovw", 1, 8);

    clearMon8();
    applyStimulus(1'b1, 16'h0009, 1'b0);
    waitIdle8("bp_done");
    checkPass8("bp", 2, 8);

    // Reset asserted mid-pass takes effect immediately
    applyStimulus(1'b1, 16'h000A, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("midrst_pre", {31'd0, seq8}, 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_seq",   {31'd0, seq8},   0);
    checkOutput("midrst_vld",   {31'd0, vld8},   0);
    checkOutput("midrst_count", {28'd0, count8}, 0);
    checkOutput("midrst_empty", {31'd0, empty8}, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // REQ mode: request while empty is ignored
    mode8 = 1'b1;
    clearMon8();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("req_empty", seq_cnt8, 0);
    applyStimulus(1'b1, 16'h000A, 1'b0);
    applyStimulus(1'b1, 16'h000B, 1'b0);
    applyStimulus(1'b1, 16'h000C, 1'b0);
    checkOutput("req_no_auto", {31'd0, seq8}, 0);
    clearMon8();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("req_trig", {31'd0, seq8}, 1);
    waitIdle8("req_done");
    checkPass8("req", 'hA, 3);

    // Same-cycle write and request includes the new sample
    resetPulse();
    mode8 = 1'b1;
    applyStimulus(1'b1, 16'h000A, 1'b0);
    applyStimulus(1'b1, 16'h000B, 1'b0);
    clearMon8();
    applyStimulus(1'b1, 16'h000C, 1'b1);
    waitIdle8("same_done");
    checkPass8("same", 'hA, 3);
    checkOutput("same_count", {28'd0, count8}, 3);
    checkOutput("vld_inside_seq", viol8, 0);

    // DEPTH=1024 overwrite and wrap
    resetPulse();
    for (int i = 0; i < 1024; i++) begin
      wrtk = 1'b1;
      newk = 16'(i);
      @(negedge clk);
    end
    wrtk = 1'b0;
    checkOutput("wrap_trig", {31'd0, seqk}, 1);
    for (int i = 0; i < 1100 && seqk; i++) @(negedge clk);
    checkOutput("wrap_first_done", {31'd0, seqk}, 0);
    checkOutput("wrap_full", {31'd0, fullk}, 1);
    for (int j = 1024; j < 1027; j++) begin
      qk.delete();
      wrtk = 1'b1;
      newk = 16'(j);
      @(negedge clk);
      wrtk = 1'b0;
      checkOutput($sformatf("wrap_count%0d", j), {21'd0, countk}, 1024);
      for (int i = 0; i < 1100 && seqk; i++) @(negedge clk);
      checkOutput($sformatf("wrap_done%0d", j), {31'd0, seqk}, 0);
    end
    checkOutput("wrap_size", qk.size(), 1024);
    for (int i = 0; i < 1024 && i < qk.size(); i++)
      checkOutput($sformatf("wrap_smp%0d", i), {16'd0, qk[i]}, i + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
